pipe_stage_ctrl: RTL and testbench
==================================

Name: pipe_stage_ctrl

Overview:
- Parametrised pipeline stage manager for the RISC core.
- Holds the per-stage valid bit, PC and control bundle for DEPTH stages (stage 0 = ID, 1 = EX, 2 = ME, 3 = WB at default).
- Generates operand-forward selects for the instruction in ID, the load-use stall and branch flush, and an external freeze.
- Counts stall and flush events; sits between the instruction decoder and the datapath stage registers.

Parameters:
- DEPTH, 4: number of stages after IF; legal range 2..8.
- PC_W, 32: PC width.
- CTL_W, 16: opaque control-bundle width (RW/MD/BS/PS/MW/FS packed by the top level).
- RA_W, 5: register address width; address 0 is the hardwired zero register.
- FLUSH_STAGE, 1: stage in which branches resolve; legal range 1..DEPTH-1.
- CNT_W, 16: width of the performance counters.
- SEL_W, $clog2(DEPTH): derived forward-select width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous reset, active-high.
- ext_stall  in  1  freeze every stage (memory wait).
- br_taken  in  1  branch in stage FLUSH_STAGE is taken.
- in_valid  in  1  IF presents an instruction.
- in_pc  in  PC_W  PC of the IF instruction.
- in_ctl  in  CTL_W  decoded control bundle.
- in_da, in_aa, in_ba  in  RA_W each  destination and source register addresses.
- in_rw  in  1  instruction writes a register.
- in_ld  in  1  instruction is a load (result available only after stage 2).
- in_a_use, in_b_use  in  1 each  source A / source B is read.
- st_valid  out  DEPTH  per-stage valid; bit k = stage k.
- st_pc  out  DEPTH*PC_W  per-stage PC; stage k in slice [k*PC_W +: PC_W].
- st_ctl  out  DEPTH*CTL_W  per-stage control bundle, same slicing.
- st_da  out  DEPTH*RA_W  per-stage destination address, same slicing.
- st_rw  out  DEPTH  per-stage register-write enable, already qualified by valid.
- fwd_a, fwd_b  out  SEL_W each  forward source for ID operand A / B; 0 = register file, k = stage k.
- if_hold  out  1  IF must hold its PC and instruction this cycle.
- stall_cnt, flush_cnt  out  CNT_W each  saturating event counters.

Behaviour:
- Reset (rst=1 at an edge): every stage becomes a bubble and both counters clear. Bubble = valid 0, rw 0, ld 0, pc 0, ctl 0, da 0.
- After reset, fwd_a=fwd_b=0 and if_hold=0.
- Stage 0 additionally stores aa, ba, a_use, b_use and ld. Stages 1..DEPTH-1 store ld.
- Forward select (combinational, from stage 0):
  - Candidates are stages k in 1..DEPTH-1 with valid, rw, da==aa, da!=0 and a_use.
  - fwd_a = smallest such k, i.e. the youngest producer; 0 if none. fwd_b is the same using ba and b_use.
  - fwd_a/fwd_b are 0 whenever stage 0 is invalid.
- Load-use hazard: fwd_a==1 or fwd_b==1, and stage 1 ld=1.
- Cycle action, priority rst > ext_stall > br_taken > hazard > advance:
  - ext_stall: all stages hold; counters hold; if_hold=1.
  - br_taken: stages 1..FLUSH_STAGE receive bubbles. Stage FLUSH_STAGE+1 receives the branch if FLUSH_STAGE+1 < DEPTH. Older stages advance. Stage 0 loads a bubble, discarding the IF instruction. if_hold=0, so IF fetches the target. flush_cnt+1.
  - hazard (no flush): stage 0 holds; stage 1 gets a bubble; stages >=2 advance; if_hold=1; stall_cnt+1.
  - advance: stage k takes stage k-1. Stage 0 takes the in_* fields, or a bubble if in_valid=0. if_hold=0.
- The oldest stage retires each advance; there is no back-pressure beyond ext_stall.
- Counters saturate at all-ones and do not wrap.
- Flush during a load-use stall: the flush wins and the stalled ID instruction is discarded.
- The stall lasts exactly one cycle per load-use, because the load moves to stage 2 and is forwarded from there.
- rst asserted mid-stall or mid-flush: reset wins, with the same result as a clean reset.
- Latency: in_* fields appear on stage 0 outputs one cycle after an advance edge.

Decomposition:
- Shared package pipe_pkg holds:
  - localparams for the stage indices ID=0, EX=1, ME=2, WB=3;
  - the bubble constant;
  - the function computing the youngest-match forward select.
- One sub-module: pipe_stage_reg, a single stage register with load/hold/bubble controls and a synchronous clear. It is instantiated DEPTH times in a generate loop.
- Hazard and forward logic stays in the top module.

Test Plan:
- Reset, then feed 6 independent ALU ops PC 0..5 -> st_pc stage 3 = 0 at cycle 4; fwd 0; if_hold 0; counters 0.
- ADD R3 then SUB R4,R3,R3 -> fwd_a=fwd_b=1 while SUB is in ID. With one gap instruction -> 2. With R0 as destination -> 0.
- LD R5 then ADD R6,R5,R1 -> one cycle with if_hold=1 and a stage 1 bubble; then fwd_a=2; stall_cnt=1.
- br_taken at the branch in EX (FLUSH_STAGE=1) -> stages 0 and 1 become bubbles; the branch appears in stage 2; flush_cnt=1. A simultaneous load-use is ignored (stall_cnt unchanged).
- ext_stall for 3 cycles mid-stream -> all st_* stable and if_hold=1. Release resumes in order with no loss or duplication.
- Sweeps: DEPTH=6, FLUSH_STAGE=3 flush -> stages 1..3 bubbled. Force 65535 hazards with CNT_W=16 -> stall_cnt stays 0xFFFF. rst during a stall -> all valid 0 on the next cycle.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline stage manager:
// stage indices, bubble flags and the youngest-producer select.
package pipe_pkg;

    localparam int ID = 0;
    localparam int EX = 1;
    localparam int ME = 2;
    localparam int WB = 3;

    localparam int MAX_DEPTH = 8;
    localparam int MAX_SEL_W = 3;

    typedef struct packed {
        logic valid;
        logic rw;
        logic ld;
    } stg_flags_t;

    localparam stg_flags_t BUBBLE = '0;

    // Lowest matching stage index wins: that is the youngest producer.
    function automatic logic [MAX_SEL_W-1:0] youngest_sel(
        input logic [MAX_DEPTH-1:0] hit
    );
        logic [MAX_SEL_W-1:0] sel;
        sel = '0;
        for (int k = MAX_DEPTH - 1; k >= 1; k--) begin
            if (hit[k]) sel = MAX_SEL_W'(k);
        end
        return sel;
    endfunction

endpackage

// File: rtl/pipe_stage_ctrl_if.sv
// Bundle between decoder/IF, the stage manager and the datapath.
// master drives instructions and pipeline events, slave is the manager.
interface pipe_stage_ctrl_if
    import pipe_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PC_W  = 32,
    parameter int CTL_W = 16,
    parameter int RA_W  = 5,
    parameter int CNT_W = 16,
    parameter int SEL_W = $clog2(DEPTH)
);
    logic                   ext_stall;
    logic                   br_taken;
    logic                   in_valid;
    logic [PC_W-1:0]        in_pc;
    logic [CTL_W-1:0]       in_ctl;
    logic [RA_W-1:0]        in_da;
    logic [RA_W-1:0]        in_aa;
    logic [RA_W-1:0]        in_ba;
    logic                   in_rw;
    logic                   in_ld;
    logic                   in_a_use;
    logic                   in_b_use;

    logic [DEPTH-1:0]       st_valid;
    logic [DEPTH*PC_W-1:0]  st_pc;
    logic [DEPTH*CTL_W-1:0] st_ctl;
    logic [DEPTH*RA_W-1:0]  st_da;
    logic [DEPTH-1:0]       st_rw;
    logic [SEL_W-1:0]       fwd_a;
    logic [SEL_W-1:0]       fwd_b;
    logic                   if_hold;
    logic [CNT_W-1:0]       stall_cnt;
    logic [CNT_W-1:0]       flush_cnt;

    modport master (
        output ext_stall, br_taken, in_valid, in_pc, in_ctl,
        output in_da, in_aa, in_ba, in_rw, in_ld, in_a_use, in_b_use,
        input  st_valid, st_pc, st_ctl, st_da, st_rw,
        input  fwd_a, fwd_b, if_hold, stall_cnt, flush_cnt
    );

    modport slave (
        input  ext_stall, br_taken, in_valid, in_pc, in_ctl,
        input  in_da, in_aa, in_ba, in_rw, in_ld, in_a_use, in_b_use,
        output st_valid, st_pc, st_ctl, st_da, st_rw,
        output fwd_a, fwd_b, if_hold, stall_cnt, flush_cnt
    );

endinterface

// File: rtl/pipe_stage_reg.sv
// One pipeline stage register: load, hold, or collapse to a bubble.
// A bubble is the all-zero word; rst clears it the same way.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic         bubble_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] data_q;

    always_ff @(posedge clk) begin
        if (rst || bubble_i) begin
            data_q <= '0;
        end else if (load_i) begin
            data_q <= d_i;
        end
    end

    assign q_o = data_q;

endmodule

// File: rtl/pipe_stage_ctrl.sv
// Pipeline stage manager: per-stage valid/PC/control, forwarding
// selects for ID, load-use stall, branch flush and event counters.
module pipe_stage_ctrl
    import pipe_pkg::*;
#(
    parameter int DEPTH       = 4,
    parameter int PC_W        = 32,
    parameter int CTL_W       = 16,
    parameter int RA_W        = 5,
    parameter int FLUSH_STAGE = 1,
    parameter int CNT_W       = 16,
    parameter int SEL_W       = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    pipe_stage_ctrl_if.slave  bus
);

    localparam int WK = 3 + RA_W + CTL_W + PC_W;
    localparam int WX = 2 + 2 * RA_W;

    logic [WK-1:0]        ent [DEPTH];
    logic [WX-1:0]        id_ext;
    logic [DEPTH-1:0]     s_v;
    logic [DEPTH-1:0]     s_rw;
    logic [DEPTH-1:0]     s_ld;
    logic [PC_W-1:0]      s_pc  [DEPTH];
    logic [CTL_W-1:0]     s_ctl [DEPTH];
    logic [RA_W-1:0]      s_da  [DEPTH];
    logic [RA_W-1:0]      id_aa;
    logic [RA_W-1:0]      id_ba;
    logic                 id_au;
    logic                 id_bu;
    stg_flags_t           in_flags;

    logic [MAX_DEPTH-1:0] hit_a;
    logic [MAX_DEPTH-1:0] hit_b;
    logic [SEL_W-1:0]     fwd_a;
    logic [SEL_W-1:0]     fwd_b;
    logic                 hazard;
    logic                 flush;
    logic                 stall;
    logic                 adv;
    logic [DEPTH-1:0]     load;
    logic [DEPTH-1:0]     bubble;

    logic [CNT_W-1:0]     stall_cnt_q;
    logic [CNT_W-1:0]     stall_cnt_d;
    logic [CNT_W-1:0]     flush_cnt_q;
    logic [CNT_W-1:0]     flush_cnt_d;
    logic                 unused_ld;

    assign in_flags = bus.in_valid
        ? stg_flags_t'{valid: 1'b1, rw: bus.in_rw, ld: bus.in_ld}
        : BUBBLE;

    // Stage 0 carries the source operands on top of the common entry.
    for (genvar k = 0; k < DEPTH; k++) begin : g_st
        if (k == ID) begin : g_id
            logic [WX+WK-1:0] q0;
            pipe_stage_reg #(.W(WX + WK)) u_reg (
                .clk      (clk),
                .rst      (rst),
                .load_i   (load[k]),
                .bubble_i (bubble[k]),
                .d_i      ({bus.in_a_use, bus.in_b_use,
                            bus.in_aa, bus.in_ba, in_flags,
                            bus.in_da, bus.in_ctl, bus.in_pc}),
                .q_o      (q0)
            );
            assign {id_ext, ent[k]} = q0;
        end else begin : g_nx
            pipe_stage_reg #(.W(WK)) u_reg (
                .clk      (clk),
                .rst      (rst),
                .load_i   (load[k]),
                .bubble_i (bubble[k]),
                .d_i      (ent[k-1]),
                .q_o      (ent[k])
            );
        end
    end

    assign {id_au, id_bu, id_aa, id_ba} = id_ext;

    always_comb begin
        for (int k = 0; k < DEPTH; k++) begin
            {s_v[k], s_rw[k], s_ld[k],
             s_da[k], s_ctl[k], s_pc[k]} = ent[k];
        end
    end

    always_comb begin
        hit_a = '0;
        hit_b = '0;
        for (int k = 1; k < DEPTH; k++) begin
            hit_a[k] = s_v[ID] && s_v[k] && s_rw[k] && id_au
                && (s_da[k] == id_aa) && (s_da[k] != '0);
            hit_b[k] = s_v[ID] && s_v[k] && s_rw[k] && id_bu
                && (s_da[k] == id_ba) && (s_da[k] != '0);
        end
    end

    assign fwd_a = SEL_W'(youngest_sel(hit_a));
    assign fwd_b = SEL_W'(youngest_sel(hit_b));

    // A load in EX has no result yet; wait one cycle and take it from ME.
    assign hazard = s_ld[EX]
        && (fwd_a == SEL_W'(EX) || fwd_b == SEL_W'(EX));

    assign flush = !bus.ext_stall && bus.br_taken;
    assign stall = !bus.ext_stall && !bus.br_taken && hazard;
    assign adv   = !bus.ext_stall && !bus.br_taken && !hazard;

    always_comb begin
        load   = '0;
        bubble = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (k == ID) begin
                bubble[k] = flush || (adv && !bus.in_valid);
                load[k]   = adv && bus.in_valid;
            end else begin
                bubble[k] = (flush && k <= FLUSH_STAGE)
                    || (stall && k == EX);
                load[k]   = adv || (flush && k > FLUSH_STAGE)
                    || (stall && k > EX);
            end
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall && stall_cnt_q != '1) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        if (flush && flush_cnt_q != '1) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    always_comb begin
        bus.st_valid = s_v;
        bus.st_rw    = s_v & s_rw;
        bus.st_pc    = '0;
        bus.st_ctl   = '0;
        bus.st_da    = '0;
        for (int k = 0; k < DEPTH; k++) begin
            bus.st_pc[k*PC_W +: PC_W]    = s_pc[k];
            bus.st_ctl[k*CTL_W +: CTL_W] = s_ctl[k];
            bus.st_da[k*RA_W +: RA_W]    = s_da[k];
        end
    end

    assign bus.fwd_a     = fwd_a;
    assign bus.fwd_b     = fwd_b;
    assign bus.if_hold   = bus.ext_stall || stall;
    assign bus.stall_cnt = stall_cnt_q;
    assign bus.flush_cnt = flush_cnt_q;

    assign unused_ld = ^s_ld;

endmodule

// File: tb/tb_pipe_stage_ctrl.sv
// Scoreboard bench: stimulus queues timed expectations and retire PCs,
// a negedge monitor pops and compares them against two DUT configs.
module tb_pipe_stage_ctrl;

    localparam int U0_V    = 0;
    localparam int U0_FA   = 1;
    localparam int U0_FB   = 2;
    localparam int U0_HOLD = 3;
    localparam int U0_SC   = 4;
    localparam int U0_FC   = 5;
    localparam int U0_PC0  = 6;
    localparam int U0_PC2  = 7;
    localparam int U1_V    = 8;
    localparam int U1_SC   = 9;
    localparam int U1_FC   = 10;
    localparam int U1_PC4  = 11;

    typedef struct {
        int          cyc;
        int          sig;
        logic [31:0] val;
        string       nm;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    logic ret_ok = 1'b0;

    exp_t        q_exp [$];
    logic [31:0] ret_q [$];

    pipe_stage_ctrl_if #(.DEPTH(4), .CNT_W(16)) b0 ();
    pipe_stage_ctrl_if #(.DEPTH(6), .CNT_W(4))  b1 ();

    pipe_stage_ctrl #(.DEPTH(4), .FLUSH_STAGE(1), .CNT_W(16)) u0 (
        .clk (clk),
        .rst (rst),
        .bus (b0)
    );

    pipe_stage_ctrl #(.DEPTH(6), .FLUSH_STAGE(3), .CNT_W(4)) u1 (
        .clk (clk),
        .rst (rst),
        .bus (b1)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc    <= cyc + 1;
        ret_ok <= !b0.ext_stall && !rst;
    end

    function automatic logic [31:0] obs(input int s);
        case (s)
            U0_V:    obs = 32'(b0.st_valid);
            U0_FA:   obs = 32'(b0.fwd_a);
            U0_FB:   obs = 32'(b0.fwd_b);
            U0_HOLD: obs = 32'(b0.if_hold);
            U0_SC:   obs = 32'(b0.stall_cnt);
            U0_FC:   obs = 32'(b0.flush_cnt);
            U0_PC0:  obs = b0.st_pc[0 +: 32];
            U0_PC2:  obs = b0.st_pc[64 +: 32];
            U1_V:    obs = 32'(b1.st_valid);
            U1_SC:   obs = 32'(b1.stall_cnt);
            U1_FC:   obs = 32'(b1.flush_cnt);
            U1_PC4:  obs = b1.st_pc[128 +: 32];
            default: obs = 32'hDEAD_BEEF;
        endcase
    endfunction

    always @(negedge clk) begin
        exp_t        e;
        logic [31:0] got;
        logic [31:0] want;
        while (q_exp.size() > 0 && q_exp[0].cyc <= cyc) begin
            e = q_exp.pop_front();
            n_checks++;
            if (e.cyc < cyc) begin
                n_fail++;
                $display("FAIL %s: stale at cycle %0d, wanted cycle %0d",
                         e.nm, cyc, e.cyc);
            end else begin
                got = obs(e.sig);
                if (got !== e.val) begin
                    n_fail++;
                    $display("FAIL %s: got %h expected %h (cycle %0d)",
                             e.nm, got, e.val, cyc);
                end
            end
        end
        if (ret_ok && b0.st_valid[3]) begin
            n_checks++;
            got = b0.st_pc[96 +: 32];
            if (ret_q.size() == 0) begin
                n_fail++;
                $display("FAIL retire: got pc %h expected none", got);
            end else begin
                want = ret_q.pop_front();
                if (got !== want) begin
                    n_fail++;
                    $display("FAIL retire: got pc %h expected %h",
                             got, want);
                end
            end
        end
    end

    task automatic ex(input int sig, input logic [31:0] v,
                      input string nm);
        exp_t e;
        e.cyc = cyc;
        e.sig = sig;
        e.val = v;
        e.nm  = nm;
        q_exp.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put0(input int v, input int pc, input int da,
                        input int aa, input int ba, input int rw,
                        input int ld, input int au, input int bu);
        b0.in_valid = 1'(v);
        b0.in_pc    = 32'(pc);
        b0.in_ctl   = 16'(pc ^ 32'hA5A5);
        b0.in_da    = 5'(da);
        b0.in_aa    = 5'(aa);
        b0.in_ba    = 5'(ba);
        b0.in_rw    = 1'(rw);
        b0.in_ld    = 1'(ld);
        b0.in_a_use = 1'(au);
        b0.in_b_use = 1'(bu);
    endtask

    task automatic put1(input int v, input int pc, input int da,
                        input int aa, input int ba, input int rw,
                        input int ld, input int au, input int bu);
        b1.in_valid = 1'(v);
        b1.in_pc    = 32'(pc);
        b1.in_ctl   = 16'(pc ^ 32'h5A5A);
        b1.in_da    = 5'(da);
        b1.in_aa    = 5'(aa);
        b1.in_ba    = 5'(ba);
        b1.in_rw    = 1'(rw);
        b1.in_ld    = 1'(ld);
        b1.in_a_use = 1'(au);
        b1.in_b_use = 1'(bu);
    endtask

    task automatic pad(input int n);
        put0(0, 0, 0, 0, 0, 0, 0, 0, 0);
        put1(0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (n) tick();
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int   n;
        int   guard;
        logic hold;

        b0.ext_stall = 1'b0;
        b0.br_taken  = 1'b0;
        b1.ext_stall = 1'b0;
        b1.br_taken  = 1'b0;
        put0(0, 0, 0, 0, 0, 0, 0, 0, 0);
        put1(0, 0, 0, 0, 0, 0, 0, 0, 0);
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        ex(U0_V, 32'h0, "rst_valid");
        ex(U0_FA, 32'h0, "rst_fwd_a");
        ex(U0_FB, 32'h0, "rst_fwd_b");
        ex(U0_HOLD, 32'h0, "rst_hold");
        ex(U0_SC, 32'h0, "rst_stall_cnt");
        ex(U0_FC, 32'h0, "rst_flush_cnt");
        ex(U1_V, 32'h0, "rst_valid_d6");

        // Six independent ALU ops.
        for (int i = 0; i < 6; i++) begin
            put0(1, i, 10 + i, 1, 2, 1, 0, 1, 1);
            ret_q.push_back(32'(i));
            ex(U0_FA, 32'h0, "alu_fwd_a");
            ex(U0_HOLD, 32'h0, "alu_hold");
            if (i == 4) ex(U0_V, 32'hF, "alu_full");
            tick();
        end
        pad(5);
        ex(U0_SC, 32'h0, "alu_stall_cnt");
        ex(U0_FC, 32'h0, "alu_flush_cnt");
        tick();

        // Back-to-back dependency forwards from EX.
        put0(1, 'h10, 3, 1, 2, 1, 0, 1, 1);
        ret_q.push_back(32'h10);
        tick();
        put0(1, 'h11, 4, 3, 3, 1, 0, 1, 1);
        ret_q.push_back(32'h11);
        tick();
        pad(0);
        ex(U0_FA, 32'h1, "fwd1_a");
        ex(U0_FB, 32'h1, "fwd1_b");
        ex(U0_HOLD, 32'h0, "fwd1_hold");
        pad(5);

        // One gap instruction forwards from ME.
        put0(1, 'h20, 7, 1, 2, 1, 0, 1, 1);
        ret_q.push_back(32'h20);
        tick();
        put0(1, 'h21, 8, 1, 2, 1, 0, 1, 1);
        ret_q.push_back(32'h21);
        tick();
        put0(1, 'h22, 9, 7, 7, 1, 0, 1, 1);
        ret_q.push_back(32'h22);
        tick();
        pad(0);
        ex(U0_FA, 32'h2, "fwd2_a");
        ex(U0_FB, 32'h2, "fwd2_b");
        pad(5);

        // Writes to R0 never forward.
        put0(1, 'h30, 0, 1, 2, 1, 0, 1, 1);
        ret_q.push_back(32'h30);
        tick();
        put0(1, 'h31, 10, 0, 0, 1, 0, 1, 1);
        ret_q.push_back(32'h31);
        tick();
        pad(0);
        ex(U0_FA, 32'h0, "fwd_r0_a");
        ex(U0_FB, 32'h0, "fwd_r0_b");
        ex(U0_HOLD, 32'h0, "fwd_r0_hold");
        pad(5);

        // Unused source B never forwards.
        put0(1, 'h38, 11, 1, 2, 1, 0, 1, 1);
        ret_q.push_back(32'h38);
        tick();
        put0(1, 'h39, 12, 11, 11, 1, 0, 1, 0);
        ret_q.push_back(32'h39);
        tick();
        pad(0);
        ex(U0_FA, 32'h1, "fwd_buse_a");
        ex(U0_FB, 32'h0, "fwd_buse_b");
        pad(5);

        // Load-use: one stall, then forward from ME.
        put0(1, 'h40, 5, 1, 0, 1, 1, 1, 0);
        ret_q.push_back(32'h40);
        tick();
        put0(1, 'h41, 6, 5, 1, 1, 0, 1, 1);
        ret_q.push_back(32'h41);
        tick();
        put0(1, 'h42, 12, 1, 2, 1, 0, 1, 1);
        ret_q.push_back(32'h42);
        ex(U0_HOLD, 32'h1, "lu_hold");
        ex(U0_FA, 32'h1, "lu_fwd_a_ex");
        ex(U0_SC, 32'h0, "lu_stall_cnt_pre");
        tick();
        ex(U0_HOLD, 32'h0, "lu_hold_release");
        ex(U0_FA, 32'h2, "lu_fwd_a_me");
        ex(U0_V, 32'h5, "lu_bubble");
        ex(U0_SC, 32'h1, "lu_stall_cnt");
        tick();
        pad(5);

        // Taken branch in EX with a simultaneous load-use.
        put0(1, 'h50, 9, 1, 2, 1, 1, 1, 1);
        ret_q.push_back(32'h50);
        tick();
        put0(1, 'h51, 13, 9, 1, 1, 0, 1, 1);
        tick();
        put0(1, 'h52, 14, 1, 2, 1, 0, 1, 1);
        b0.br_taken = 1'b1;
        ex(U0_HOLD, 32'h0, "br_hold");
        ex(U0_FA, 32'h1, "br_lu_seen");
        tick();
        b0.br_taken = 1'b0;
        put0(1, 'h60, 15, 1, 2, 1, 0, 1, 1);
        ret_q.push_back(32'h60);
        ex(U0_V, 32'h4, "br_valid");
        ex(U0_PC2, 32'h50, "br_pc2");
        ex(U0_FC, 32'h1, "br_flush_cnt");
        ex(U0_SC, 32'h1, "br_stall_kept");
        tick();
        pad(5);

        // Three-cycle freeze mid-stream.
        put0(1, 'h70, 16, 1, 2, 1, 0, 1, 1);
        ret_q.push_back(32'h70);
        tick();
        put0(1, 'h71, 17, 1, 2, 1, 0, 1, 1);
        ret_q.push_back(32'h71);
        tick();
        put0(1, 'h72, 18, 1, 2, 1, 0, 1, 1);
        ret_q.push_back(32'h72);
        tick();
        put0(1, 'h73, 19, 1, 2, 1, 0, 1, 1);
        ret_q.push_back(32'h73);
        b0.ext_stall = 1'b1;
        for (int j = 0; j < 3; j++) begin
            ex(U0_HOLD, 32'h1, "frz_hold");
            ex(U0_V, 32'h7, "frz_valid");
            ex(U0_PC0, 32'h72, "frz_pc0");
            tick();
        end
        b0.ext_stall = 1'b0;
        ex(U0_V, 32'h7, "frz_release_valid");
        ex(U0_PC0, 32'h72, "frz_release_pc0");
        ex(U0_HOLD, 32'h0, "frz_release_hold");
        ex(U0_SC, 32'h1, "frz_stall_cnt");
        ex(U0_FC, 32'h1, "frz_flush_cnt");
        tick();
        pad(6);

        // DEPTH=6, FLUSH_STAGE=3: flush clears stages 1..3.
        for (int i = 0; i < 4; i++) begin
            put1(1, 'h80 + i, 20 + i, 1, 2, 1, 0, 1, 1);
            tick();
        end
        put1(1, 'h84, 24, 1, 2, 1, 0, 1, 1);
        b1.br_taken = 1'b1;
        ex(U1_V, 32'h0F, "d6_pre_valid");
        tick();
        b1.br_taken = 1'b0;
        put1(0, 0, 0, 0, 0, 0, 0, 0, 0);
        ex(U1_V, 32'h10, "d6_flush_valid");
        ex(U1_PC4, 32'h80, "d6_pc4");
        ex(U1_FC, 32'h1, "d6_flush_cnt");
        tick();
        pad(7);

        // Dependent load chain: 19 load-use stalls saturate a 4-bit count.
        n = 0;
        guard = 0;
        while (n < 20 && guard < 200) begin
            put1(1, 'h100 + n, 1, 1, 0, 1, 1, 1, 0);
            #1;
            hold = b1.if_hold;
            tick();
            if (!hold) n++;
            guard++;
        end
        if (guard >= 200) begin
            n_checks++;
            n_fail++;
            $display("FAIL sat_loop: got %0d issued expected 20", n);
        end
        pad(7);
        ex(U1_SC, 32'hF, "sat_stall_cnt");
        ex(U1_FC, 32'h1, "sat_flush_kept");
        tick();

        // Reset asserted in the middle of a load-use stall.
        put0(1, 'h90, 5, 1, 0, 1, 1, 1, 0);
        tick();
        put0(1, 'h91, 6, 5, 1, 1, 0, 1, 1);
        tick();
        put0(1, 'h92, 7, 1, 2, 1, 0, 1, 1);
        ex(U0_HOLD, 32'h1, "rst_pre_hold");
        rst = 1'b1;
        tick();
        rst = 1'b0;
        put0(0, 0, 0, 0, 0, 0, 0, 0, 0);
        ex(U0_V, 32'h0, "rst_stall_valid");
        ex(U0_SC, 32'h0, "rst_stall_cnt2");
        ex(U0_FC, 32'h0, "rst_flush_cnt2");
        ex(U0_HOLD, 32'h0, "rst_stall_hold");
        ex(U1_V, 32'h0, "rst_d6_valid");
        ex(U1_SC, 32'h0, "rst_d6_stall_cnt");
        tick();
        pad(3);

        n_checks++;
        if (ret_q.size() != 0) begin
            n_fail++;
            $display("FAIL retire_drain: got %0d pending expected 0",
                     ret_q.size());
        end
        n_checks++;
        if (q_exp.size() != 0) begin
            n_fail++;
            $display("FAIL exp_drain: got %0d pending expected 0",
                     q_exp.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
